// File: rtl/draw_pkg.sv
// Shared geometry, colours and state encoding for the character draw scheduler.
// Lane origins are fixed; the walker and scheduler both read them from here.
package draw_pkg;

    localparam int CHAR_W = 9;
    localparam int CHAR_H = 5;

    localparam logic [6:0] CHAR_Y     = 7'd102;
    localparam logic [2:0] COLOR_CHAR = 3'b011;
    localparam logic [2:0] COLOR_BG   = 3'b000;

    localparam logic [7:0] LANE_X [0:3] = '{8'd6, 8'd24, 8'd78, 8'd132};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_EXT
    } state_t;

    function automatic logic [7:0] lane_x(input logic [1:0] lane);
        return LANE_X[lane];
    endfunction

endpackage

// File: rtl/rect_walker.sv
// Emits the 9x5 character rectangle one pixel per cycle in row-major order.
// A start pulse coincident with the last pixel begins the next rectangle with no gap.
module rect_walker
    import draw_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_base_x,
    input  logic [6:0] i_base_y,
    output logic [7:0] o_x,
    output logic [6:0] o_y,
    output logic       o_valid,
    output logic       o_last
);

    localparam logic [3:0] LAST_COL = 4'(CHAR_W - 1);
    localparam logic [2:0] LAST_ROW = 3'(CHAR_H - 1);

    logic [7:0] r_x;
    logic [7:0] r_x0;
    logic [6:0] r_y;
    logic [3:0] r_col;
    logic [2:0] r_row;
    logic       r_valid;
    logic       w_last;

    assign w_last = r_valid && (r_col == LAST_COL) && (r_row == LAST_ROW);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_x     <= 8'd0;
            r_x0    <= 8'd0;
            r_y     <= 7'd0;
            r_col   <= 4'd0;
            r_row   <= 3'd0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_x     <= i_base_x;
            r_x0    <= i_base_x;
            r_y     <= i_base_y;
            r_col   <= 4'd0;
            r_row   <= 3'd0;
            r_valid <= 1'b1;
        end else if (r_valid) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else if (r_col == LAST_COL) begin
                r_col <= 4'd0;
                r_row <= r_row + 3'd1;
                r_x   <= r_x0;
                r_y   <= r_y + 7'd1;
            end else begin
                r_col <= r_col + 4'd1;
                r_x   <= r_x + 8'd1;
            end
        end
    end

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_valid = r_valid;
    assign o_last  = w_last;

endmodule

// File: rtl/char_draw_scheduler.sv
// Owns the VGA pixel port: draws/erases the character on lane moves and
// round-robins the port with one external drawer.
module char_draw_scheduler
    import draw_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_pos_req,
    input  logic [1:0] i_new_pos,
    input  logic       i_ext_req,
    input  logic       i_ext_done,
    input  logic [7:0] i_ext_x,
    input  logic [6:0] i_ext_y,
    input  logic [2:0] i_ext_color,
    input  logic       i_ext_plot,
    output logic       o_ext_grant,
    output logic [7:0] o_x_out,
    output logic [6:0] o_y_out,
    output logic [2:0] o_color,
    output logic       o_plot,
    output logic [1:0] o_cur_pos,
    output logic       o_busy,
    output logic       o_move_done
);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_pending;
    logic [1:0] r_target;
    logic [1:0] r_move_tgt;
    logic [1:0] r_cur_pos;
    logic       r_last_ext;
    logic       r_done_pend;
    logic       r_move_done;
    logic       r_busy;
    logic       r_grant;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_color;
    logic       r_plot;

    logic [7:0] w_walk_x;
    logic [6:0] w_walk_y;
    logic       w_walk_valid;
    logic       w_walk_last;
    logic       w_walk_start;
    logic [7:0] w_base_x;
    logic       w_take_move;
    logic       w_done_set;

    rect_walker u_walker (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (w_walk_start),
        .i_base_x (w_base_x),
        .i_base_y (CHAR_Y),
        .o_x      (w_walk_x),
        .o_y      (w_walk_y),
        .o_valid  (w_walk_valid),
        .o_last   (w_walk_last)
    );

    // The walker start in IDLE erases the current lane; in ERASE it chains the draw.
    always_comb begin
        w_base_x = lane_x(2'd0);
        case (r_state)
            S_IDLE:  w_base_x = lane_x(r_cur_pos);
            S_ERASE: w_base_x = lane_x(r_move_tgt);
            default: w_base_x = lane_x(2'd0);
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_walk_start = 1'b0;
        w_take_move  = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_walk_start = !w_walk_valid;
                if (w_walk_last) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                // Nothing starts while CurPos is still being updated from the last move.
                if (!r_done_pend) begin
                    if (r_pending && (!i_ext_req || r_last_ext)) begin
                        w_take_move = 1'b1;
                        if (r_target == r_cur_pos) begin
                            w_done_set = 1'b1;
                        end else begin
                            w_state_nxt  = S_ERASE;
                            w_walk_start = 1'b1;
                        end
                    end else if (i_ext_req) begin
                        w_state_nxt = S_EXT;
                    end
                end
            end
            S_ERASE: begin
                if (w_walk_last) begin
                    w_state_nxt  = S_DRAW;
                    w_walk_start = 1'b1;
                end
            end
            S_DRAW: begin
                if (w_walk_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            S_EXT: begin
                if (i_ext_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_INIT;
            r_pending   <= 1'b0;
            r_target    <= 2'd0;
            r_move_tgt  <= 2'd0;
            r_cur_pos   <= 2'd0;
            r_last_ext  <= 1'b1;
            r_done_pend <= 1'b0;
            r_move_done <= 1'b0;
            r_busy      <= 1'b0;
            r_grant     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_pos_req) begin
                r_pending <= 1'b1;
                r_target  <= i_new_pos;
            end else if (w_take_move) begin
                r_pending <= 1'b0;
            end
            if (w_take_move) begin
                r_move_tgt <= r_target;
                r_last_ext <= 1'b0;
            end else if (r_state == S_IDLE && w_state_nxt == S_EXT) begin
                r_last_ext <= 1'b1;
            end
            r_done_pend <= w_done_set;
            r_move_done <= r_done_pend;
            if (r_done_pend) r_cur_pos <= r_move_tgt;
            r_busy  <= (w_state_nxt != S_IDLE) || w_done_set;
            r_grant <= (w_state_nxt == S_EXT);
        end
    end

    // Pixel port register: external copy during EXT, otherwise the walker.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_x     <= 8'd0;
            r_y     <= 7'd0;
            r_color <= 3'd0;
            r_plot  <= 1'b0;
        end else if (r_state == S_EXT) begin
            r_x     <= i_ext_x;
            r_y     <= i_ext_y;
            r_color <= i_ext_color;
            r_plot  <= i_ext_plot;
        end else begin
            r_plot <= w_walk_valid;
            if (w_walk_valid) begin
                r_x     <= w_walk_x;
                r_y     <= w_walk_y;
                r_color <= (r_state == S_ERASE) ? COLOR_BG : COLOR_CHAR;
            end
        end
    end

    assign o_ext_grant = r_grant;
    assign o_x_out     = r_x;
    assign o_y_out     = r_y;
    assign o_color     = r_color;
    assign o_plot      = r_plot;
    assign o_cur_pos   = r_cur_pos;
    assign o_busy      = r_busy;
    assign o_move_done = r_move_done;

endmodule

// File: tb/tb_char_draw_scheduler.sv
// Scoreboard bench for char_draw_scheduler: expected pixels are queued as
// stimulus is driven and popped whenever the DUT plots.
module tb_char_draw_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pos_req = 1'b0;
    logic [1:0] new_pos = 2'd0;
    logic       ext_req = 1'b0;
    logic       ext_done = 1'b0;
    logic [7:0] ext_x = 8'd0;
    logic [6:0] ext_y = 7'd0;
    logic [2:0] ext_color = 3'd0;
    logic       ext_plot = 1'b0;
    logic       ext_grant;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color;
    logic       plot;
    logic [1:0] cur_pos;
    logic       busy;
    logic       move_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_exp;
    int lane_x_tb [4] = '{6, 24, 78, 132};

    char_draw_scheduler dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_pos_req   (pos_req),
        .i_new_pos   (new_pos),
        .i_ext_req   (ext_req),
        .i_ext_done  (ext_done),
        .i_ext_x     (ext_x),
        .i_ext_y     (ext_y),
        .i_ext_color (ext_color),
        .i_ext_plot  (ext_plot),
        .o_ext_grant (ext_grant),
        .o_x_out     (x_out),
        .o_y_out     (y_out),
        .o_color     (color),
        .o_plot      (plot),
        .o_cur_pos   (cur_pos),
        .o_busy      (busy),
        .o_move_done (move_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rect(input int lane, input logic [2:0] col);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 9; c++)
                exp_q.push_back({8'(lane_x_tb[lane] + c), 7'(102 + r), col});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (move_done) done_cnt++;
        if (plot) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_plot", {14'd0, x_out, y_out, color}, 32'h3ffff);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("pixel", {14'd0, x_out, y_out, color}, {14'd0, mon_exp});
            end
        end
    end

    // called just after an edge that sampled reset high
    task automatic init_after_reset(input string tag);
        check_val({tag, "_rst_plot"}, plot, 0);
        check_val({tag, "_rst_xyc"}, {x_out, y_out, color}, 0);
        check_val({tag, "_rst_grant"}, ext_grant, 0);
        check_val({tag, "_rst_curpos"}, cur_pos, 0);
        check_val({tag, "_rst_busy"}, busy, 0);
        check_val({tag, "_rst_done"}, move_done, 0);
        exp_q.delete();
        push_rect(0, 3'b011);
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_val({tag, "_init_plot"}, plot, (k >= 2 && k <= 46) ? 1 : 0);
        end
        check_val({tag, "_init_busy"}, busy, 0);
        check_val({tag, "_init_curpos"}, cur_pos, 0);
    endtask

    task automatic move_timed(input int from, input int to);
        push_rect(from, 3'b000);
        push_rect(to, 3'b011);
        pos_req = 1'b1;
        new_pos = 2'(to);
        step();
        pos_req = 1'b0;
        for (int k = 1; k <= 92; k++) begin
            step();
            check_val("move_plot", plot, (k >= 2 && k <= 91) ? 1 : 0);
            check_val("move_busy", busy, (k <= 91) ? 1 : 0);
            check_val("move_done", move_done, (k == 92) ? 1 : 0);
            if (k == 91) check_val("move_curpos_old", cur_pos, 32'(from));
        end
        check_val("move_curpos_new", cur_pos, 32'(to));
    endtask

    task automatic move_same(input int lane);
        pos_req = 1'b1;
        new_pos = 2'(lane);
        step();
        pos_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_val("same_plot", plot, 0);
            check_val("same_done", move_done, (k == 2) ? 1 : 0);
        end
    endtask

    task automatic ext_then_move();
        int n;
        logic p;
        pos_req = 1'b1;
        new_pos = 2'd0;
        ext_req = 1'b1;
        step();
        pos_req = 1'b0;
        check_val("ext_grant_first", ext_grant, 1);
        p = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ext_x     = 8'($urandom_range(0, 255));
            ext_y     = 7'($urandom_range(0, 127));
            ext_color = 3'($urandom_range(0, 7));
            p         = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ext_plot  = p;
            if (p) exp_q.push_back({ext_x, ext_y, ext_color});
            step();
            check_val("ext_plot_mirror", plot, p);
            check_val("ext_grant_hold", ext_grant, 1);
        end
        ext_plot = 1'b0;
        ext_done = 1'b1;
        push_rect(2, 3'b000);
        push_rect(0, 3'b011);
        step();
        ext_done = 1'b0;
        check_val("ext_grant_drop", ext_grant, 0);
        check_val("ext_last_plot", plot, 0);
        // ExtReq stays high: the pending move must win this tie
        n = 0;
        while (!move_done && n < 150) begin
            step();
            n++;
            if (ext_grant) check_val("tie_move_first", ext_grant, 0);
        end
        check_val("tie_move_done", move_done, 1);
        check_val("tie_curpos", cur_pos, 0);
        n = 0;
        while (!ext_grant && n < 5) begin
            step();
            n++;
        end
        check_val("ext_grant_after_move", ext_grant, 1);
        ext_req  = 1'b0;
        ext_done = 1'b1;
        step();
        ext_done = 1'b0;
        step();
        check_val("ext_release", ext_grant, 0);
    endtask

    task automatic last_wins();
        int d0;
        d0 = done_cnt;
        push_rect(0, 3'b000);
        push_rect(2, 3'b011);
        push_rect(2, 3'b000);
        push_rect(1, 3'b011);
        pos_req = 1'b1; new_pos = 2'd2; step(); pos_req = 1'b0;
        repeat (10) step();
        pos_req = 1'b1; new_pos = 2'd3; step(); pos_req = 1'b0;
        repeat (10) step();
        pos_req = 1'b1; new_pos = 2'd1; step(); pos_req = 1'b0;
        repeat (250) step();
        check_val("lw_done_count", 32'(done_cnt - d0), 2);
        check_val("lw_curpos", cur_pos, 1);
        check_val("lw_queue", 32'(exp_q.size()), 0);
        check_val("lw_busy", busy, 0);
    endtask

    task automatic reset_mid_draw();
        int d0;
        push_rect(1, 3'b000);
        push_rect(3, 3'b011);
        pos_req = 1'b1; new_pos = 2'd3; step(); pos_req = 1'b0;
        repeat (10) step();
        pos_req = 1'b1; new_pos = 2'd2; step(); pos_req = 1'b0;
        repeat (55) step();
        check_val("mid_pix20_plot", plot, 1);
        check_val("mid_pix20_color", color, 3'b011);
        rst = 1'b1;
        step();
        init_after_reset("mid");
        d0 = done_cnt;
        repeat (100) step();
        check_val("mid_no_move", 32'(done_cnt - d0), 0);
        check_val("mid_curpos", cur_pos, 0);
    endtask

    initial begin
        step();
        step();
        init_after_reset("por");
        move_timed(0, 2);
        move_same(2);
        ext_then_move();
        last_wins();
        reset_mid_draw();
        step();
        check_val("final_queue", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/char_draw_scheduler.md
# char_draw_scheduler

- Owns the single pixel-write port of the VGA adapter.
- Sequences character moves: erases the 9x5 character at its current lane in background color, then redraws it at the new lane in character color.
- Shares the port with one external drawer (obstacles, score) by round-robin arbitration.
- Sits between the game-state FSM and the VGA adapter's x/y/colour/plot inputs.

## Interface
Parameters (none exposed; geometry fixed in package):
- none

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- PosReq  in  1  one-cycle pulse: move character to NewPos
- NewPos  in  2  target lane 0..3, sampled when PosReq=1
- ExtReq  in  1  external drawer requests port; level, held until granted
- ExtDone  in  1  external drawer finished; sampled only while ExtGrant=1
- ExtX  in  8  external pixel x
- ExtY  in  7  external pixel y
- ExtColor  in  3  external pixel colour
- ExtPlot  in  1  external pixel write enable
- ExtGrant  out  1  external drawer owns port
- XOut  out  8  pixel x to VGA adapter
- YOut  out  7  pixel y to VGA adapter
- Color  out  3  pixel colour to VGA adapter
- Plot  out  1  pixel write enable to VGA adapter
- CurPos  out  2  lane where character is currently drawn
- Busy  out  1  state != IDLE
- MoveDone  out  1  one-cycle pulse when a move completes

## Operation
- Lane x origins: 6, 24, 78, 132. All lanes use y origin 102. Character is 9 wide x 5 tall, 45 pixels.
- Character colour is 3'b011. Erase colour is 3'b000.
- States:
  - INIT: draws the character at lane 0 after reset.
  - IDLE
  - ERASE: walks CurPos in erase colour.
  - DRAW: walks target lane in character colour.
  - EXT: external drawer owns the port.
- Transitions:
  - INIT -> IDLE on the last pixel.
  - ERASE -> DRAW on the last pixel, with no gap cycle.
  - DRAW -> IDLE on the last pixel. CurPos <= target and MoveDone pulses on the following cycle.
  - EXT -> IDLE on ExtDone.
- Move request latch:
  - PosReq sets MovePending and stores Target regardless of state.
  - A second PosReq before service overwrites Target. Last request wins.
  - MovePending clears when ERASE is entered.
- IDLE arbitration, when MovePending and ExtReq are both set:
  - Serve the requester not served last.
  - LastServed resets to EXT, so after INIT a move wins the first tie.
  - A single requester is served immediately.
- Move with Target == CurPos: no pixels are plotted. Go IDLE and pulse MoveDone the next cycle.
- During EXT, outputs are registered copies of the Ext* inputs (one cycle latency). ExtGrant stays high until the cycle after ExtDone.
- During ERASE, DRAW and INIT, ExtGrant=0 and Ext* inputs are ignored.
- Pixel scan: row-major. x advances fastest from origin to origin+8, then y advances from 102 to 106.
- Coordinate arithmetic: 8-bit x and 7-bit y. No wrap is possible; maximum values are x=140 and y=106.

## Timing
- Reset values: XOut=0, YOut=0, Color=0, Plot=0, ExtGrant=0, CurPos=0, Busy=0, MoveDone=0. MovePending=0, LastServed=EXT, state=INIT.
- First INIT pixel: Plot=1 two cycles after Reset deasserts. 45 consecutive Plot cycles follow.
- Move from IDLE, with PosReq at cycle t:
  - Erase pixels at t+2..t+46.
  - Draw pixels at t+47..t+91.
  - MoveDone and new CurPos at t+92.
  - Busy high from t+1 to t+91.
- Plot is low on every cycle not listed above, except EXT, where Plot follows ExtPlot delayed by one cycle.
- Reset mid-operation: on the next edge all outputs take reset values and any pending move is dropped. The INIT draw then restarts at lane 0. The scheduler never re-erases the old position.

## Structure
- Package draw_pkg contains:
  - LANE_X[0:3]
  - CHAR_Y=102, CHAR_W=9, CHAR_H=5
  - COLOR_CHAR=3'b011, COLOR_BG=3'b000
  - the state enum
- Sub-module rect_walker:
  - Inputs: Start pulse, base x/y.
  - Outputs: x, y, Valid, Last.
  - Behaviour: one pixel per cycle, and it restarts on Start coincident with Last.
- The scheduler instantiates one rect_walker, shared by INIT, ERASE and DRAW.

## Test plan
- Reset release:
  - Expect 45 Plot cycles with Color=011, x 6..14 and y 102..106 in row-major order.
  - Then Busy=0 and CurPos=0.
- PosReq with NewPos=2 from IDLE:
  - Expect 45 pixels of colour 000 at x 6..14, then 45 pixels of colour 011 at x 78..86, contiguous.
  - MoveDone pulses at t+92 and CurPos=2.
- PosReq with NewPos==CurPos:
  - No Plot.
  - MoveDone pulses exactly once, two cycles after the request.
- PosReq and ExtReq in the same cycle, after a previous move:
  - ExtGrant is given first. Plot mirrors ExtPlot delayed one cycle.
  - After ExtDone, the move runs.
  - Repeating the tie serves the move first.
- During a move, PosReq NewPos=3 then PosReq NewPos=1:
  - After the first move completes, exactly one further move runs, to lane 1.
- Reset asserted at the 20th draw pixel:
  - Next cycle Plot=0, ExtGrant=0, CurPos=0.
  - A fresh 45-pixel draw at lane 0 follows, and the pending move is discarded.
